// File: rtl/host_rd_pkg.sv
// Shared types and widths for the host-side readout sequencer.
package host_rd_pkg;

    localparam int HDATA_W = 24;
    localparam int NHIT_W  = 9;
    localparam int ADDR_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FETCH,
        S_SEND,
        S_FIN
    } state_t;

endpackage

// File: rtl/host_reader_if.sv
// Valid/ready word stream carrying buffer words out of host_reader.
interface host_reader_if;
    import host_rd_pkg::*;

    logic [HDATA_W-1:0] data;
    logic               valid;
    logic               ready;
    logic               last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/host_reader_wait_timer.sv
// Timeout counter for the BUSY waits: cleared by clr, saturates at TMO-1.
module wait_timer #(
    parameter int TMO = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TMO - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/host_reader.sv
// Host-side sequencer: triggers one scan on readout_1, waits on BUSY, then
// streams the event's buffer words out with LAST on the final word.
module host_reader
    import host_rd_pkg::*;
#(
    parameter int START_W = 2,
    parameter int RD_LAT  = 1,
    parameter int DEPTH   = 256,
    parameter int TMO     = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig,
    output logic                start,
    output logic                sel,
    output logic [ADDR_W-1:0]   haddr,
    input  logic                busy,
    input  logic [NHIT_W-1:0]   hnhit,
    input  logic [HDATA_W-1:0]  hdata,
    host_reader_if.master       strm,
    output logic [NHIT_W-1:0]   evt_nhit,
    output logic                ovfl,
    output logic                done,
    output logic                tmo_err
);
    localparam int PW = (START_W > 1) ? $clog2(START_W) : 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [NHIT_W-1:0] DEPTH_N = NHIT_W'(DEPTH);

    state_t            state;
    logic [PW-1:0]     pulse_cnt;
    logic [LW-1:0]     lat_cnt;
    logic [NHIT_W-1:0] n_rd;
    logic              tmr_clr;
    logic              tmr_expired;

    // The timer restarts on entry to each BUSY wait, including WAIT_HI -> WAIT_LO.
    assign tmr_clr = !((state == S_WAIT_HI) || (state == S_WAIT_LO))
                   || ((state == S_WAIT_HI) && busy);

    wait_timer #(.TMO(TMO)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    // NOTE: every output is a flop cleared by the async reset, so a mid-event reset drops SEL/VALID at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start       <= 1'b0;
            sel         <= 1'b0;
            haddr       <= '0;
            n_rd        <= '0;
            pulse_cnt   <= '0;
            lat_cnt     <= '0;
            evt_nhit    <= '0;
            ovfl        <= 1'b0;
            done        <= 1'b0;
            tmo_err     <= 1'b0;
            strm.data   <= '0;
            strm.valid  <= 1'b0;
            strm.last   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (trig) begin
                    state     <= S_PULSE;
                    start     <= 1'b1;
                    sel       <= 1'b1;
                    pulse_cnt <= '0;
                    ovfl      <= 1'b0;
                    tmo_err   <= 1'b0;
                end
                S_PULSE: begin
                    if (pulse_cnt == PW'(START_W - 1)) begin
                        start <= 1'b0;
                        state <= S_WAIT_HI;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (busy) begin
                        state <= S_WAIT_LO;
                    end else if (tmr_expired) begin
                        tmo_err <= 1'b1;
                        sel     <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end
                end
                S_WAIT_LO: begin
                    if (!busy) begin
                        evt_nhit <= hnhit;
                        n_rd     <= (hnhit > DEPTH_N) ? DEPTH_N : hnhit;
                        ovfl     <= (hnhit > DEPTH_N);
                        haddr    <= '0;
                        lat_cnt  <= '0;
                        if (hnhit == '0) begin
                            sel   <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (tmr_expired) begin
                        tmo_err <= 1'b1;
                        sel     <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == LW'(RD_LAT - 1)) begin
                        strm.data  <= hdata;
                        strm.valid <= 1'b1;
                        strm.last  <= ({1'b0, haddr} == n_rd - NHIT_W'(1));
                        state      <= S_SEND;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_SEND: if (strm.ready) begin
                    strm.valid <= 1'b0;
                    strm.last  <= 1'b0;
                    if (strm.last) begin
                        sel   <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        haddr   <= haddr + 1'b1;
                        lat_cnt <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_reader.sv
// Directed bench for host_reader: readout_1 modelled as a BUSY driver plus a
// buffer whose word is 0x0A0100 + HADDR; a second instance covers the timeout.
module tb_host_reader;
    import host_rd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: normal timeout, streams words
    logic               trig_a, start_a, sel_a, busy_a, ovfl_a, done_a, tmo_err_a;
    logic [ADDR_W-1:0]  haddr_a;
    logic [NHIT_W-1:0]  hnhit_a, evt_nhit_a;
    logic [HDATA_W-1:0] hdata_a;
    host_reader_if ifa ();

    assign hdata_a = 24'h0A0100 + {16'h0, haddr_a};

    host_reader #(.START_W(2), .RD_LAT(1), .DEPTH(256), .TMO(4096)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig_a),
        .start    (start_a),
        .sel      (sel_a),
        .haddr    (haddr_a),
        .busy     (busy_a),
        .hnhit    (hnhit_a),
        .hdata    (hdata_a),
        .strm     (ifa),
        .evt_nhit (evt_nhit_a),
        .ovfl     (ovfl_a),
        .done     (done_a),
        .tmo_err  (tmo_err_a)
    );

    // Instance B: TMO=16, BUSY never rises
    logic               trig_b, start_b, sel_b, busy_b, ovfl_b, done_b, tmo_err_b;
    logic [ADDR_W-1:0]  haddr_b;
    logic [NHIT_W-1:0]  hnhit_b, evt_nhit_b;
    logic [HDATA_W-1:0] hdata_b;
    host_reader_if ifb ();

    host_reader #(.START_W(2), .RD_LAT(1), .DEPTH(256), .TMO(16)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig_b),
        .start    (start_b),
        .sel      (sel_b),
        .haddr    (haddr_b),
        .busy     (busy_b),
        .hnhit    (hnhit_b),
        .hdata    (hdata_b),
        .strm     (ifb),
        .evt_nhit (evt_nhit_b),
        .ovfl     (ovfl_b),
        .done     (done_b),
        .tmo_err  (tmo_err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream monitor / consumer for A, pulse counters for both instances
    int            word_cnt = 0, stall_word = 0, stall_left = 0;
    int            done_cnt_a = 0, done_cnt_b = 0, valid_cnt_b = 0;
    logic          stalled = 1'b0;
    logic [HDATA_W:0] held;
    logic [HDATA_W:0] rx_q[$];

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (ifb.valid) valid_cnt_b++;
        if (ifa.valid) begin
            if (word_cnt + 1 == stall_word && stall_left > 0) begin
                if (stalled) check("stall_hold", {7'h0, ifa.last, ifa.data}, {7'h0, held});
                held       = {ifa.last, ifa.data};
                stalled    = 1'b1;
                stall_left--;
                ifa.ready  = 1'b0;
            end else begin
                if (stalled) check("stall_release", {7'h0, ifa.last, ifa.data}, {7'h0, held});
                stalled   = 1'b0;
                ifa.ready = 1'b1;
                rx_q.push_back({ifa.last, ifa.data});
                word_cnt++;
            end
        end else begin
            if (stalled) check("valid_held", {31'h0, ifa.valid}, 32'h1);
            stalled   = 1'b0;
            ifa.ready = 1'b1;
        end
    end

    task automatic clear_mon();
        word_cnt   = 0;
        stall_word = 0;
        stall_left = 0;
        stalled    = 1'b0;
        done_cnt_a = 0;
        rx_q.delete();
    endtask

    // Trigger A, check the START pulse, then run BUSY high for 20 cycles.
    task automatic start_event_a(input int nhit);
        hnhit_a = nhit[NHIT_W-1:0];
        @(negedge clk) trig_a = 1'b1;
        @(negedge clk) trig_a = 1'b0;
        check("start_first", {31'h0, start_a}, 32'h1);
        check("sel_up", {31'h0, sel_a}, 32'h1);
        check("ovfl_clr", {31'h0, ovfl_a}, 32'h0);
        @(negedge clk);
        check("start_second", {31'h0, start_a}, 32'h1);
        @(negedge clk);
        check("start_end", {31'h0, start_a}, 32'h0);
        busy_a = 1'b1;
        repeat (20) @(negedge clk);
        busy_a = 1'b0;
    endtask

    task automatic finish_event_a(input int budget);
        int t = 0;
        while (done_cnt_a == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt_a, 1);
        check("sel_dropped", {31'h0, sel_a}, 32'h0);
    endtask

    task automatic check_words(input int n);
        logic [HDATA_W:0] exp;
        check("n_words", rx_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < n; i++) begin
            exp = {(i == n - 1), 24'h0A0100 + 24'(i)};
            check($sformatf("word%0d", i), {7'h0, rx_q[i]}, {7'h0, exp});
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        trig_a    = 1'b0;
        busy_a    = 1'b0;
        hnhit_a   = '0;
        trig_b    = 1'b0;
        busy_b    = 1'b0;
        hnhit_b   = '0;
        hdata_b   = '0;
        ifa.ready = 1'b1;
        ifb.ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start", {31'h0, start_a}, 32'h0);
        check("rst_sel", {31'h0, sel_a}, 32'h0);
        check("rst_valid", {31'h0, ifa.valid}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_evt", {23'h0, evt_nhit_a}, 32'h0);
        check("rst_flags", {30'h0, ovfl_a, tmo_err_a}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: three words
        clear_mon();
        start_event_a(3);
        finish_event_a(200);
        check_words(3);
        check("t1_evt", {23'h0, evt_nhit_a}, 32'd3);
        check("t1_ovfl", {31'h0, ovfl_a}, 32'h0);
        check("t1_tmo", {31'h0, tmo_err_a}, 32'h0);

        // 2: empty event
        clear_mon();
        start_event_a(0);
        finish_event_a(200);
        check_words(0);
        check("t2_evt", {23'h0, evt_nhit_a}, 32'd0);

        // 3: overflow clamps to 256 words
        clear_mon();
        start_event_a(300);
        finish_event_a(2000);
        check_words(256);
        check("t3_evt", {23'h0, evt_nhit_a}, 32'd300);
        check("t3_ovfl", {31'h0, ovfl_a}, 32'h1);

        // exactly DEPTH hits: full read, no overflow
        clear_mon();
        start_event_a(256);
        finish_event_a(2000);
        check_words(256);
        check("t3b_evt", {23'h0, evt_nhit_a}, 32'd256);
        check("t3b_ovfl", {31'h0, ovfl_a}, 32'h0);

        // 4: backpressure on word 2
        clear_mon();
        stall_word = 2;
        stall_left = 5;
        start_event_a(4);
        finish_event_a(300);
        check_words(4);
        check("t4_evt", {23'h0, evt_nhit_a}, 32'd4);

        // 5: timeout with BUSY stuck low, twice to see TMO_ERR clear on PULSE
        for (int r = 0; r < 2; r++) begin
            done_cnt_b = 0;
            @(negedge clk) trig_b = 1'b1;
            @(negedge clk) trig_b = 1'b0;
            t = 1;
            check("t5_tmo_clr", {31'h0, tmo_err_b}, 32'h0);
            while (!done_b && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("t5_latency", t, 2 + 16 + 1);
            check("t5_tmo_err", {31'h0, tmo_err_b}, 32'h1);
            check("t5_sel", {31'h0, sel_b}, 32'h0);
            check("t5_evt", {23'h0, evt_nhit_b}, 32'h0);
            repeat (3) @(negedge clk);
            check("t5_done_pulses", done_cnt_b, 1);
            check("t5_no_valid", valid_cnt_b, 0);
        end

        // 6: reset during SEND of word 2 of 5
        clear_mon();
        stall_word = 2;
        stall_left = 1000;
        start_event_a(5);
        t = 0;
        while (!stalled && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_in_word2", {31'h0, stalled}, 32'h1);
        #2;
        rst_n      = 1'b0;
        stall_left = 0;
        stalled    = 1'b0;
        #1;
        check("t6_sel", {31'h0, sel_a}, 32'h0);
        check("t6_valid", {31'h0, ifa.valid}, 32'h0);
        check("t6_last", {31'h0, ifa.last}, 32'h0);
        check("t6_data", {8'h0, ifa.data}, 32'h0);
        check("t6_haddr", {24'h0, haddr_a}, 32'h0);
        check("t6_evt", {23'h0, evt_nhit_a}, 32'h0);
        check("t6_misc", {28'h0, start_a, done_a, ovfl_a, tmo_err_a}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        start_event_a(5);
        finish_event_a(300);
        check_words(5);
        check("t6_clean_evt", {23'h0, evt_nhit_a}, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
